lsu_request_ctrl: RTL



---
 rtl/lsu_request_ctrl_if.sv | 38 +++
 rtl/lsu_request_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_request_ctrl_if.sv
// Bundle of the pipeline request/response signals and the data cache request signals
// seen by the load/store request controller.
interface lsu_request_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_busy;

    // Environment view: pipeline MEM stage plus the data cache.
    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        output mem_read_data, mem_busy,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
        input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
    );

    // Controller view.
    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        input  mem_read_data, mem_busy,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
        output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
    );
endinterface

// File: rtl/lsu_request_ctrl.sv
// Load/store request controller: decodes and screens one MEM-stage access, issues a
// single-cycle cache strobe, follows the cache busy window and returns one response pulse.
module lsu_request_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    lsu_request_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_t;

    state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic        is_load_reg, is_load_next;
    logic        memread_reg, memread_next;
    logic        memwrite_reg, memwrite_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  mask_reg, mask_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        misaligned_reg, misaligned_next;
    logic        fault_reg, fault_next;

    logic [3:0]  dec_mask;
    logic        dec_illegal;
    logic        dec_misaligned;
    logic        req_ready_int;
    logic        accept;
    logic        timeout_hit;
    logic [31:0] load_data;

    always_comb begin
        dec_mask    = 4'b0000;
        dec_illegal = 1'b0;
        if (bus.req_load && bus.req_store) begin
            dec_illegal = 1'b1;
        end else if (bus.req_load) begin
            case (bus.req_funct3)
                3'b000:  dec_mask = 4'b1001;
                3'b001:  dec_mask = 4'b1011;
                3'b010:  dec_mask = 4'b1111;
                3'b100:  dec_mask = 4'b0001;
                3'b101:  dec_mask = 4'b0011;
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000:  dec_mask = 4'b0001;
                3'b001:  dec_mask = 4'b0011;
                3'b010:  dec_mask = 4'b0111;
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Alignment follows the access size encoded in funct3[1:0].
    always_comb begin
        dec_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   dec_misaligned = bus.req_addr[0];
            2'b10:   dec_misaligned = |bus.req_addr[1:0];
            default: dec_misaligned = 1'b0;
        endcase
    end

    // Stores return zero data, so the captured word is gated by the access type.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_load_data
            assign load_data[gi] = bus.mem_read_data[gi] & is_load_reg;
        end
    endgenerate

    assign req_ready_int = (state_reg == IDLE) && !bus.mem_busy;
    assign accept        = bus.req_valid && req_ready_int && (bus.req_load || bus.req_store);
    assign cnt_inc       = cnt_reg + CNT_W'(1);
    assign timeout_hit   = (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        is_load_next    = is_load_reg;
        memread_next    = 1'b0;
        memwrite_next   = 1'b0;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        mask_next       = mask_reg;
        resp_valid_next = 1'b0;
        rdata_next      = rdata_reg;
        misaligned_next = misaligned_reg;
        fault_next      = fault_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (dec_illegal || dec_misaligned) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        rdata_next      = 32'd0;
                        misaligned_next = dec_misaligned;
                        fault_next      = dec_illegal;
                    end else begin
                        state_next    = ISSUE;
                        cnt_next      = '0;
                        is_load_next  = bus.req_load;
                        memread_next  = bus.req_load;
                        memwrite_next = bus.req_store;
                        addr_next     = bus.req_addr;
                        wdata_next    = bus.req_wdata;
                        mask_next     = dec_mask;
                    end
                end
            end
            ISSUE: begin
                state_next = WAIT_HI;
            end
            WAIT_HI, WAIT_LO: begin
                cnt_next = cnt_inc;
                if (state_reg == WAIT_HI && bus.mem_busy) begin
                    state_next = WAIT_LO;
                end else if (state_reg == WAIT_LO && !bus.mem_busy) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    rdata_next      = load_data;
                    misaligned_next = 1'b0;
                    fault_next      = 1'b0;
                end else if (timeout_hit) begin
                    // A normal exit on the last allowed cycle wins over the timeout.
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    rdata_next      = 32'd0;
                    misaligned_next = 1'b0;
                    fault_next      = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            is_load_reg    <= 1'b0;
            memread_reg    <= 1'b0;
            memwrite_reg   <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            mask_reg       <= 4'd0;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= 32'd0;
            misaligned_reg <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            is_load_reg    <= is_load_next;
            memread_reg    <= memread_next;
            memwrite_reg   <= memwrite_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            mask_reg       <= mask_next;
            resp_valid_reg <= resp_valid_next;
            rdata_reg      <= rdata_next;
            misaligned_reg <= misaligned_next;
            fault_reg      <= fault_next;
        end
    end

    assign bus.req_ready       = req_ready_int;
    assign bus.resp_valid      = resp_valid_reg;
    assign bus.resp_rdata      = rdata_reg;
    assign bus.resp_misaligned = misaligned_reg;
    assign bus.resp_fault      = fault_reg;
    assign bus.mem_addr        = addr_reg;
    assign bus.mem_write_data  = wdata_reg;
    assign bus.mem_memread     = memread_reg;
    assign bus.mem_memwrite    = memwrite_reg;
    assign bus.mem_sign_mask   = mask_reg;
endmodule
